// File: rtl/chessboard_renderer.sv
`default_nettype none
// ============================================================================
// chessboard_renderer: two-stage pipelined procedural chessboard pixel source
// with board flip, selected-square fill and a blinking cursor border.
// Revision: 1.0
// ============================================================================
module chessboard_renderer #(
  parameter int          ORIGIN_X     = 80,
  parameter int          ORIGIN_Y     = 0,
  parameter int          SQ_SIZE      = 60,
  parameter int          BOARD_N      = 8,
  parameter int          BORDER_W     = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] LIGHT_RGB    = 12'hEDB,
  parameter logic [11:0] DARK_RGB     = 12'h865,
  parameter logic [11:0] SEL_RGB      = 12'hBC4,
  parameter logic [11:0] CUR_RGB      = 12'h0F0,
  localparam int         OFF_W        = $clog2(SQ_SIZE)
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             flip,
  input  logic [2:0]       cursor_file,
  input  logic [2:0]       cursor_rank,
  input  logic             sel_valid,
  input  logic [2:0]       sel_file,
  input  logic [2:0]       sel_rank,
  input  logic             blink_en,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             boardon,
  output logic [2:0]       sq_file,
  output logic [2:0]       sq_rank,
  output logic [OFF_W-1:0] sq_off_x,
  output logic [OFF_W-1:0] sq_off_y
);

  localparam int               FC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [9:0]       X_START  = 10'(ORIGIN_X);
  localparam logic [9:0]       Y_START  = 10'(ORIGIN_Y);
  localparam logic [10:0]      X_END    = 11'(ORIGIN_X + BOARD_N * SQ_SIZE);
  localparam logic [10:0]      Y_END    = 11'(ORIGIN_Y + BOARD_N * SQ_SIZE);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SQ_SIZE - 1);
  localparam logic [OFF_W-1:0] BW_LO    = OFF_W'(BORDER_W);
  localparam logic [OFF_W-1:0] BW_HI    = OFF_W'(SQ_SIZE - BORDER_W);
  localparam logic [2:0]       N_LAST   = 3'(BOARD_N - 1);
  localparam logic [3:0]       N_LIM    = 4'(BOARD_N);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  // offx_q/offy_q double as the stage-1 offset registers of the pixel in flight
  logic [OFF_W-1:0] offx_q, offx_d, offy_q, offy_d;
  logic [2:0]       col_q, col_d, row_q, row_d;
  logic [9:0]       prev_y_q;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             blink_q, blink_d;

  logic             inside_q, inside_d;
  logic [2:0]       file_q, file_d, rank_q, rank_d;
  logic             cur_hit_q, cur_hit_d, sel_hit_q, sel_hit_d, dark_q, dark_d;

  logic [11:0]      rgb_q, rgb_d;
  logic             boardon_q, boardon_d;
  logic [2:0]       sq_file_q, sq_file_d, sq_rank_q, sq_rank_d;
  logic [OFF_W-1:0] sq_off_x_q, sq_off_x_d, sq_off_y_q, sq_off_y_d;

  logic             x_in, y_in, row_chg, frame_start, border;

  always_comb begin
    x_in        = (DrawX >= X_START) && ({1'b0, DrawX} < X_END);
    y_in        = (DrawY >= Y_START) && ({1'b0, DrawY} < Y_END);
    row_chg     = (DrawY != prev_y_q);
    frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

    offx_d = offx_q;
    col_d  = col_q;
    if (DrawX == X_START) begin
      offx_d = '0;
      col_d  = 3'd0;
    end else if (x_in) begin
      if (offx_q == OFF_LAST) begin
        offx_d = '0;
        col_d  = col_q + 3'd1;
      end else begin
        offx_d = offx_q + 1'b1;
      end
    end

    offy_d = offy_q;
    row_d  = row_q;
    if (row_chg) begin
      if (DrawY == Y_START) begin
        offy_d = '0;
        row_d  = 3'd0;
      end else if (offy_q == OFF_LAST) begin
        offy_d = '0;
        row_d  = row_q + 3'd1;
      end else begin
        offy_d = offy_q + 1'b1;
      end
    end

    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_start) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Stage 1: screen square to board square, plus per-square match flags
  always_comb begin
    inside_d  = x_in && y_in;
    file_d    = flip ? (N_LAST - col_d) : col_d;
    rank_d    = flip ? row_d : (N_LAST - row_d);
    cur_hit_d = (file_d == cursor_file) && (rank_d == cursor_rank) &&
                ({1'b0, cursor_file} < N_LIM) && ({1'b0, cursor_rank} < N_LIM);
    sel_hit_d = sel_valid && (file_d == sel_file) && (rank_d == sel_rank) &&
                ({1'b0, sel_file} < N_LIM) && ({1'b0, sel_rank} < N_LIM);
    dark_d    = (file_d[0] == rank_d[0]);
  end

  // Stage 2: colour priority; coordinates are zeroed off-board
  always_comb begin
    border     = (offx_q < BW_LO) || (offx_q >= BW_HI) ||
                 (offy_q < BW_LO) || (offy_q >= BW_HI);
    rgb_d      = 12'h000;
    boardon_d  = 1'b0;
    sq_file_d  = 3'd0;
    sq_rank_d  = 3'd0;
    sq_off_x_d = '0;
    sq_off_y_d = '0;
    if (inside_q) begin
      boardon_d  = 1'b1;
      sq_file_d  = file_q;
      sq_rank_d  = rank_q;
      sq_off_x_d = offx_q;
      sq_off_y_d = offy_q;
      if (cur_hit_q && border && (blink_q || !blink_en)) begin
        rgb_d = CUR_RGB;
      end else if (sel_hit_q) begin
        rgb_d = SEL_RGB;
      end else if (dark_q) begin
        rgb_d = DARK_RGB;
      end else begin
        rgb_d = LIGHT_RGB;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      offx_q     <= '0;
      offy_q     <= '0;
      col_q      <= 3'd0;
      row_q      <= 3'd0;
      prev_y_q   <= 10'd0;
      fcnt_q     <= '0;
      blink_q    <= 1'b1;
      inside_q   <= 1'b0;
      file_q     <= 3'd0;
      rank_q     <= 3'd0;
      cur_hit_q  <= 1'b0;
      sel_hit_q  <= 1'b0;
      dark_q     <= 1'b0;
      rgb_q      <= 12'h000;
      boardon_q  <= 1'b0;
      sq_file_q  <= 3'd0;
      sq_rank_q  <= 3'd0;
      sq_off_x_q <= '0;
      sq_off_y_q <= '0;
    end else begin
      offx_q     <= offx_d;
      offy_q     <= offy_d;
      col_q      <= col_d;
      row_q      <= row_d;
      prev_y_q   <= DrawY;
      fcnt_q     <= fcnt_d;
      blink_q    <= blink_d;
      inside_q   <= inside_d;
      file_q     <= file_d;
      rank_q     <= rank_d;
      cur_hit_q  <= cur_hit_d;
      sel_hit_q  <= sel_hit_d;
      dark_q     <= dark_d;
      rgb_q      <= rgb_d;
      boardon_q  <= boardon_d;
      sq_file_q  <= sq_file_d;
      sq_rank_q  <= sq_rank_d;
      sq_off_x_q <= sq_off_x_d;
      sq_off_y_q <= sq_off_y_d;
    end
  end

  assign red      = rgb_q[11:8];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[3:0];
  assign boardon  = boardon_q;
  assign sq_file  = sq_file_q;
  assign sq_rank  = sq_rank_q;
  assign sq_off_x = sq_off_x_q;
  assign sq_off_y = sq_off_y_q;

endmodule
`default_nettype wire
